// File: rtl/i2c_bus_model.sv
// ---------------------------------------------------------------------------
// i2c_bus_model
//
// Self-contained I2C transaction model. It holds a bit-serial master and a
// bank of eight single-register slaves. The master and the slaves share one
// internal open-drain SDA line. SCL advances one bit per clk.
//
// Each frame performs one of two operations on the slave picked by maddr:
//   - write one byte to it, or
//   - read one byte back from it.
//
// Frame layout, one clk per state or bit:
//   START, ADDR x7, RW, AACK, DATA x8, DACK, STOP
// That is 20 clk per frame, plus one IDLE clk between back-to-back frames.
//
// Parameters:
//   ADDR_PREFIX : upper four bits of every slave's 7-bit address.
//
// Ports:
//   clk   : system clock; all state changes on its rising edge
//   rst   : asynchronous active-low reset
//   en    : start a frame whenever the engine is idle
//   maddr : slave index 0..7, sampled at frame start
//   data  : write payload, sampled at frame start
//   wr    : 1 = write, 0 = read, sampled at frame start
//   sdata : slave register touched by the most recent completed frame
//   out   : byte returned by the most recent completed read frame
// ---------------------------------------------------------------------------
module i2c_bus_model #(
  parameter logic [3:0] ADDR_PREFIX = 4'b1010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] maddr,
  input  logic [7:0] data,
  input  logic       wr,
  output logic [7:0] sdata,
  output logic [7:0] out
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    RW,
    AACK,
    DATA,
    DACK,
    STOP
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] bit_cnt;

  // Master side: request latched in IDLE.
  logic [2:0] maddr_l;
  logic [7:0] data_l;
  logic       wr_l;
  logic [6:0] tx_addr;

  // Slave side: what the slaves have decoded off the wire.
  logic [6:0] rx_addr;
  logic       rx_rw;
  logic [7:0] match;
  logic [7:0] slave_reg [8];

  // This one shift register captures whatever is on SDA during DATA.
  // On a write, it holds the byte the addressed slave received.
  // On a read, it holds the byte the master received.
  logic [7:0] shift_reg;

  // Open-drain bus: each agent releases (1) or pulls low (0).
  logic       master_sda;
  logic [7:0] slave_sda;
  logic       sda;

  assign tx_addr = {ADDR_PREFIX, maddr_l};
  assign sda     = master_sda & (&slave_sda);

  // Each slave compares the captured address with its own address.
  // The prefix is fixed, so some slave always matches.
  // The no-match path is still decoded: it makes the master see a NACK.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      match[i] = (rx_addr == {ADDR_PREFIX, 3'(i)});
    end
  end

  // Slave drivers, per state:
  //   AACK : the addressed slave ACKs the address.
  //   DATA : on a read, that slave shifts its register out MSB first.
  //   DACK : on a write, that slave ACKs the data byte.
  always_comb begin
    slave_sda = '1;
    for (int i = 0; i < 8; i++) begin
      if (match[i]) begin
        case (state)
          AACK:    slave_sda[i] = 1'b0;
          DATA:    if (rx_rw) slave_sda[i] = slave_reg[i][bit_cnt];
          DACK:    if (!rx_rw) slave_sda[i] = 1'b0;
          default: slave_sda[i] = 1'b1;
        endcase
      end
    end
  end

  // Master driver.
  // The master releases SDA in every slot that a slave owns, or that carries
  // the master's read NACK, so those bits read back as 1.
  always_comb begin
    master_sda = 1'b1;
    case (state)
      START:   master_sda = 1'b0;
      ADDR:    master_sda = tx_addr[bit_cnt];
      RW:      master_sda = ~wr_l;
      DATA:    if (wr_l) master_sda = data_l[bit_cnt];
      default: master_sda = 1'b1;
    endcase
  end

  // Next-state logic.
  // In AACK the master samples the bus: a high line is a NACK, and the
  // frame jumps straight to STOP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = START;
      START:   state_nxt = ADDR;
      ADDR:    if (bit_cnt == 3'd0) state_nxt = RW;
      RW:      state_nxt = AACK;
      AACK:    state_nxt = sda ? STOP : DATA;
      DATA:    if (bit_cnt == 3'd0) state_nxt = DACK;
      DACK:    state_nxt = STOP;
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Datapath. Work done on each edge:
  //   - latch the request in IDLE
  //   - shift the address and data bits off the wire
  //   - commit the result on the edge that leaves DACK
  // A reset mid-frame clears everything, so nothing is committed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt   <= '0;
      maddr_l   <= '0;
      data_l    <= '0;
      wr_l      <= 1'b0;
      rx_addr   <= '0;
      rx_rw     <= 1'b0;
      shift_reg <= '0;
      sdata     <= '0;
      out       <= '0;
      for (int i = 0; i < 8; i++) slave_reg[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            maddr_l <= maddr;
            data_l  <= data;
            wr_l    <= wr;
          end
        end
        START: bit_cnt <= 3'd6;
        ADDR: begin
          rx_addr <= {rx_addr[5:0], sda};
          bit_cnt <= bit_cnt - 3'd1;
        end
        RW:   rx_rw <= sda;
        AACK: bit_cnt <= 3'd7;
        DATA: begin
          shift_reg <= {shift_reg[6:0], sda};
          bit_cnt   <= bit_cnt - 3'd1;
        end
        DACK: begin
          if (wr_l) begin
            if (!sda) begin
              for (int i = 0; i < 8; i++) begin
                if (match[i]) slave_reg[i] <= shift_reg;
              end
              sdata <= shift_reg;
            end
          end else begin
            out   <= shift_reg;
            sdata <= shift_reg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_model.sv
// ---------------------------------------------------------------------------
// tb_i2c_bus_model
//
// Directed bench for i2c_bus_model, built as a scoreboard.
//
// Stimulus side: when it issues a frame, it pushes the expected sdata/out
// values into a queue. Each entry is tagged with the bench cycle at which
// the DUT must present those values.
//
// Monitor side: on every falling edge it pops all entries that are due and
// compares them with the DUT outputs.
//
// Cycle bookkeeping: cyc counts rising edges.
//   - A frame is requested at a falling edge with cyc == c.
//   - It starts on the next rising edge.
//   - Its result becomes visible at the falling edge where cyc == c + 20.
// ---------------------------------------------------------------------------
module tb_i2c_bus_model;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] maddr;
  logic [7:0] data;
  logic       wr;
  logic [7:0] sdata;
  logic [7:0] out;

  typedef struct {
    int         due;
    logic [7:0] sd;
    logic [7:0] ot;
    string      name;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] prev_sd = 8'h00;
  logic [7:0] prev_ot = 8'h00;

  i2c_bus_model dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .maddr (maddr),
    .data  (data),
    .wr    (wr),
    .sdata (sdata),
    .out   (out)
  );

  // Free-running clock with a period of 10 time units.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bench cycle counter, advanced on every rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Adds one expected (sdata, out) pair, due at bench cycle "due".
  function automatic void pushExp(input int due, input logic [7:0] sd,
                                  input logic [7:0] ot, input string name);
    exp_t e;
    e.due  = due;
    e.sd   = sd;
    e.ot   = ot;
    e.name = name;
    sb.push_back(e);
  endfunction

  // Compares one scoreboard entry against the current DUT outputs.
  task automatic checkOutput(input exp_t e);
    compared++;
    if (sdata !== e.sd) begin
      mismatched++;
      $display("[TB] FAIL %s sdata: got %h expected %h (cyc %0d)", e.name, sdata, e.sd, cyc);
    end
    compared++;
    if (out !== e.ot) begin
      mismatched++;
      $display("[TB] FAIL %s out: got %h expected %h (cyc %0d)", e.name, out, e.ot, cyc);
    end
  endtask

  // Monitor: on each falling edge, drains every entry that has come due.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.due < cyc) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL %s missed: due cyc %0d, seen cyc %0d", e.name, e.due, cyc);
      end else begin
        checkOutput(e);
      end
    end
  end

  // Issues one frame, starting at a falling edge.
  // en is held for a single cycle, so it is dropped mid-frame.
  // Two expectations are queued:
  //   - the outputs one cycle before the commit must still be the old ones;
  //   - the outputs at the commit must be the new ones.
  // The task returns at a falling edge once the engine is back in IDLE.
  task automatic applyStimulus(input logic w, input logic [2:0] a,
                               input logic [7:0] d, input logic [7:0] exp_sd,
                               input logic [7:0] exp_ot, input string name);
    int c;
    c     = cyc;
    wr    = w;
    maddr = a;
    data  = d;
    en    = 1'b1;
    pushExp(c + 19, prev_sd, prev_ot, {name, "_pre"});
    pushExp(c + 20, exp_sd, exp_ot, name);
    @(negedge clk);
    en    = 1'b0;
    maddr = ~a;
    data  = ~d;
    wr    = ~w;
    while (cyc < c + 21) @(negedge clk);
    prev_sd = exp_sd;
    prev_ot = exp_ot;
  endtask

  // Watchdog: guarantees the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    rst   = 1'b0;
    en    = 1'b0;
    wr    = 1'b0;
    maddr = 3'd0;
    data  = 8'h00;
    pushExp(2, 8'h00, 8'h00, "reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Basic write, then read it back.
    applyStimulus(1'b1, 3'd5, 8'h81, 8'h81, 8'h00, "wr5");
    applyStimulus(1'b0, 3'd5, 8'h00, 8'h81, 8'h81, "rd5");
    // A slave that was never written reads back as zero.
    applyStimulus(1'b0, 3'd2, 8'h5A, 8'h00, 8'h00, "rd2_unwritten");

    // Multi-slave isolation.
    applyStimulus(1'b1, 3'd7, 8'hC6, 8'hC6, 8'h00, "wr7");
    applyStimulus(1'b1, 3'd1, 8'hF6, 8'hF6, 8'h00, "wr1");
    applyStimulus(1'b1, 3'd6, 8'hC3, 8'hC3, 8'h00, "wr6");
    applyStimulus(1'b0, 3'd1, 8'h00, 8'hF6, 8'hF6, "rd1");
    applyStimulus(1'b0, 3'd7, 8'h00, 8'hC6, 8'hC6, "rd7");
    applyStimulus(1'b0, 3'd6, 8'h00, 8'hC3, 8'hC3, "rd6");

    // With en low, no frames run and the outputs hold.
    c     = cyc;
    wr    = 1'b1;
    maddr = 3'd4;
    data  = 8'hEE;
    pushExp(c + 30, 8'hC3, 8'hC3, "idle_hold");
    while (cyc < c + 31) @(negedge clk);

    // Back-to-back frames with en held high.
    // The data input changes mid-frame: the first frame must ignore it,
    // and the second frame must pick it up.
    // The second commit must land exactly 21 cycles after the first.
    c     = cyc;
    wr    = 1'b1;
    maddr = 3'd0;
    data  = 8'h11;
    en    = 1'b1;
    pushExp(c + 20, 8'h11, 8'hC3, "b2b_first");
    pushExp(c + 40, 8'h11, 8'hC3, "b2b_gap");
    pushExp(c + 41, 8'h22, 8'hC3, "b2b_second");
    while (cyc < c + 2) @(negedge clk);
    data = 8'h22;
    while (cyc < c + 22) @(negedge clk);
    en = 1'b0;
    while (cyc < c + 42) @(negedge clk);
    prev_sd = 8'h22;
    prev_ot = 8'hC3;
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h22, 8'h22, "rd0");

    // Reset lands in the DATA phase of a write to slave 3.
    // It is asserted away from any clock edge, so the clear must be
    // asynchronous. en is held high during reset to show that it is ignored.
    c     = cyc;
    wr    = 1'b1;
    maddr = 3'd3;
    data  = 8'h5A;
    en    = 1'b1;
    @(negedge clk);
    en = 1'b0;
    while (cyc < c + 13) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    pushExp(cyc, 8'h00, 8'h00, "rst_async");
    en    = 1'b1;
    maddr = 3'd3;
    data  = 8'hFF;
    @(negedge clk);
    pushExp(cyc + 2, 8'h00, 8'h00, "rst_en_ignored");
    repeat (3) @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;
    prev_sd = 8'h00;
    prev_ot = 8'h00;
    @(negedge clk);

    // After reset, the slave registers must all be clear.
    applyStimulus(1'b0, 3'd3, 8'h00, 8'h00, 8'h00, "rd3_after_rst");
    applyStimulus(1'b0, 3'd5, 8'h00, 8'h00, 8'h00, "rd5_after_rst");
    applyStimulus(1'b0, 3'd7, 8'h00, 8'h00, 8'h00, "rd7_after_rst");

    // The engine works normally again after reset.
    applyStimulus(1'b1, 3'd3, 8'hA5, 8'hA5, 8'h00, "wr3");
    applyStimulus(1'b0, 3'd3, 8'h00, 8'hA5, 8'hA5, "rd3");

    // Any entry still queued was never checked, so it counts as a failure.
    repeat (3) @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      compared++;
      mismatched++;
      $display("[TB] FAIL %s never checked (due cyc %0d)", e.name, e.due);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/i2c_bus_model.md
Name: i2c_bus_model

Overview:
- Self-contained I2C transaction model: an internal bit-serial master and a bank of eight internal single-register slaves, joined by an internal SDA line.
- Each transaction serialises one byte write to, or one byte read from, the slave selected by a 3-bit index.
- Used as a bus-protocol reference and exerciser block; there are no external I2C pins, and SCL is one bit per clk.

Parameters:
- ADDR_PREFIX, 4'b1010, upper four bits of the 7-bit slave address; the full address is {ADDR_PREFIX, maddr}.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  transaction enable; a new frame starts whenever en=1 and the engine is idle.
- maddr  input  3  slave index 0..7, sampled at frame start.
- data  input  8  write payload, sampled at frame start.
- wr  input  1  1=write, 0=read, sampled at frame start.
- sdata  output  8  content of the slave register touched by the most recent completed frame.
- out  output  8  byte returned by the most recent completed read frame.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - All eight slave registers, the latched address/data/rw, the shift register, sdata and out clear to 8'h00.
  - Any frame in progress aborts with no register update.
- FSM states, one clk per state/bit: IDLE, START, ADDR(7 bits), RW, AACK, DATA(8 bits), DACK, STOP.
- IDLE:
  - If en=1, latch maddr, data and wr, then go to START. Otherwise remain in IDLE.
- START: drive SDA low (start condition), then go to ADDR.
- ADDR: shift out {ADDR_PREFIX, maddr_l} MSB first over 7 cycles.
- RW: send ~wr_l (0=write, 1=read per I2C).
- AACK:
  - The slave whose 7-bit address matches drives ACK (0).
  - If no slave matches (unreachable with a fixed prefix, but must be decoded), the master sees NACK. It then skips to STOP with no update.
- DATA:
  - Write: master shifts out data_l MSB first; the addressed slave shifts it in.
  - Read: the addressed slave shifts out its register MSB first; the master shifts it in.
- DACK:
  - Write: slave ACKs.
  - Read: master NACKs, ending the read.
  - On the clock edge leaving DACK:
    - Write: slave_reg[maddr_l] <= data_l; sdata <= data_l; out unchanged.
    - Read: out <= received byte; sdata <= received byte; slave register unchanged.
- STOP: stop condition, then go to IDLE.
- Timing:
  - A frame occupies 20 cycles (START through STOP).
  - With en held high, a new frame starts every 21 cycles, since IDLE lasts one cycle between frames.
  - Input changes mid-frame have no effect; only values sampled in IDLE matter.
- Control edge cases:
  - en deasserted mid-frame: the current frame completes normally, then the engine stays in IDLE.
  - en asserted during reset: ignored until rst=1.
- Outputs are registered; there are no combinational paths from inputs.
- Slave registers persist across frames until reset.

Test Plan:
- Write: rst pulse, then en=1, wr=1, maddr=5, data=8'h81 → sdata=8'h81 within 20 cycles of frame start; out stays 8'h00.
- Read-back: after the write above, wr=0, maddr=5 → at end of the read frame out=8'h81 and sdata=8'h81.
- Unwritten slave: read maddr=2 after reset → out=8'h00.
- Multi-slave isolation:
  - Write 7←8'hC6, 1←8'hF6, 6←8'hC3.
  - Read 1, 7, 6 → out=8'hF6, 8'hC6, 8'hC3 respectively.
- Control:
  - en=0 → no frames; sdata and out hold.
  - Drop en mid-write → that write still completes.
  - Back-to-back frames start exactly 21 cycles apart.
- Reset mid-frame: assert rst=0 during DATA of a write to slave 3 → slave 3 stays 8'h00, and all outputs are 8'h00 immediately.
